// File: rtl/fractal_iter_engine_if.sv
// Job/result bus of the fractal iteration engine.
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid && ready are both high. A source holds valid and its payload
// stable until that edge. A sink may raise or lower ready at any time.
// Request channel: in_valid/in_ready carry c_re, c_im, max_iter, mode, jc_re, jc_im.
// Result channel: out_valid/out_ready carry out_iter, out_escaped, rgb_out.
interface fractal_iter_engine_if #(
  parameter int W      = 32,
  parameter int ITER_W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] c_re;
  logic signed [W-1:0] c_im;
  logic [ITER_W-1:0]   max_iter;
  logic                mode;
  logic signed [W-1:0] jc_re;
  logic signed [W-1:0] jc_im;
  logic                out_valid;
  logic                out_ready;
  logic [ITER_W-1:0]   out_iter;
  logic                out_escaped;
  logic [23:0]         rgb_out;

  modport master (
    output in_valid, c_re, c_im, max_iter, mode, jc_re, jc_im, out_ready,
    input  in_ready, out_valid, out_iter, out_escaped, rgb_out
  );

  modport slave (
    input  in_valid, c_re, c_im, max_iter, mode, jc_re, jc_im, out_ready,
    output in_ready, out_valid, out_iter, out_escaped, rgb_out
  );
endinterface

// File: rtl/fractal_iter_engine.sv
// Mandelbrot/Julia escape-time engine, one iteration per clock.
// Optional feature macro: FRACTAL_JULIA_EN. When it is defined, mode=1 starts
// z at the pixel coordinate and uses (jc_re, jc_im) as c. Without it every job
// runs as Mandelbrot and the Julia inputs are ignored.
// state_dbg exposes the FSM state: 0=IDLE, 1=ITER, 2=OUT.
module fractal_iter_engine #(
  parameter int W      = 32,
  parameter int FRAC   = 28,
  parameter int ITER_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fractal_iter_engine_if.slave  bus,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Full product width, width after dropping FRAC bits, and escape-sum width.
  localparam int PW = 2 * W;
  localparam int SW = 2 * W - FRAC;
  localparam int EW = SW + 1;

  // Escape threshold 4.0 in the FRAC-scaled format, EW bits wide.
  localparam logic signed [EW-1:0] ESC_LIM =
    {{(EW - FRAC - 3){1'b0}}, 3'b100, {FRAC{1'b0}}};

  state_t state_q, state_d;

  logic signed [W-1:0] zr, zi, cr, ci;
  logic [ITER_W-1:0]   n, lim;

  logic signed [PW-1:0] p_re, p_im, p_x;
  logic signed [SW-1:0] sq_re, sq_im, x;
  logic signed [EW-1:0] mag;
  logic                 escape;
  logic signed [SW-1:0] re_full, im_full;

  logic load, step, done;

  // Products at full 2W width, then rescaled by an arithmetic shift.
  assign p_re  = PW'(zr) * PW'(zr);
  assign p_im  = PW'(zi) * PW'(zi);
  assign p_x   = PW'(zr) * PW'(zi);
  assign sq_re = SW'(p_re >>> FRAC);
  assign sq_im = SW'(p_im >>> FRAC);
  assign x     = SW'(p_x >>> FRAC);

  // |z|^2 > 4 is strict: a point sitting exactly on the radius-2 circle stays in.
  assign mag    = EW'(sq_re) + EW'(sq_im);
  assign escape = (mag > ESC_LIM);

  // Next z before truncation; only the low W bits are kept (wrapping).
  assign re_full = sq_re - sq_im + SW'(cr);
  assign im_full = (x <<< 1) + SW'(ci);

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;

`ifndef FRACTAL_JULIA_EN
  // Julia inputs have no function in this build.
  logic unused_julia;
  assign unused_julia = ^{bus.mode, bus.jc_re, bus.jc_im};
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and datapath strobes; escape outranks the iteration limit.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        if (escape || (n == lim)) begin
          done    = 1'b1;
          state_d = OUT;
        end else begin
          step = 1'b1;
        end
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Iteration datapath and registered result fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zr              <= '0;
      zi              <= '0;
      cr              <= '0;
      ci              <= '0;
      n               <= '0;
      lim             <= '0;
      bus.out_iter    <= '0;
      bus.out_escaped <= 1'b0;
      bus.rgb_out     <= '0;
    end else begin
      if (load) begin
        n   <= '0;
        lim <= bus.max_iter;
`ifdef FRACTAL_JULIA_EN
        if (bus.mode) begin
          zr <= bus.c_re;
          zi <= bus.c_im;
          cr <= bus.jc_re;
          ci <= bus.jc_im;
        end else begin
          zr <= '0;
          zi <= '0;
          cr <= bus.c_re;
          ci <= bus.c_im;
        end
`else
        zr <= '0;
        zi <= '0;
        cr <= bus.c_re;
        ci <= bus.c_im;
`endif
      end
      if (step) begin
        zr <= re_full[W-1:0];
        zi <= im_full[W-1:0];
        n  <= n + 1'b1;
      end
      if (done) begin
        // Without escape n equals the limit here, so n is the count either way.
        bus.out_iter    <= n;
        bus.out_escaped <= escape;
        bus.rgb_out     <= escape ? {8'h00, n[7:0], 8'h00} : 24'h000000;
      end
    end
  end

endmodule

// File: tb/tb_fractal_iter_engine.sv
// Directed bench for fractal_iter_engine with hand-computed expectations.
module tb_fractal_iter_engine;
  localparam int W      = 32;
  localparam int FRAC   = 28;
  localparam int ITER_W = 16;

  // Q4.28 constants.
  localparam logic [W-1:0] F_ZERO  = 32'h0000_0000;
  localparam logic [W-1:0] F_ONE   = 32'h1000_0000;
  localparam logic [W-1:0] F_2P5   = 32'h2800_0000;
  localparam logic [W-1:0] F_3P0   = 32'h3000_0000;
  localparam logic [W-1:0] F_M2P0  = 32'hE000_0000;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  fractal_iter_engine_if #(.W(W), .ITER_W(ITER_W)) bus ();

  fractal_iter_engine #(.W(W), .FRAC(FRAC), .ITER_W(ITER_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready),    64'd1);
    check({tag, "_busy"},      64'(busy),            64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid),   64'd0);
    check({tag, "_out_iter"},  64'(bus.out_iter),    64'd0);
    check({tag, "_escaped"},   64'(bus.out_escaped), 64'd0);
    check({tag, "_rgb"},       64'(bus.rgb_out),     64'd0);
    check({tag, "_state"},     64'(state_dbg),       64'd0);
  endtask

  // Present a job at the falling edge, accept on the next rising edge.
  task automatic start_job(input string tag, input logic [W-1:0] cre, input logic [W-1:0] cim,
                           input logic [ITER_W-1:0] mi, input logic md,
                           input logic [W-1:0] jre, input logic [W-1:0] jim,
                           input bit release_reset);
    @(negedge clk);
    if (release_reset) reset = 1'b0;
    bus.c_re     = cre;
    bus.c_im     = cim;
    bus.max_iter = mi;
    bus.mode     = md;
    bus.jc_re    = jre;
    bus.jc_im    = jim;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, "_busy_after_accept"}, 64'(busy),         64'd1);
    check({tag, "_in_ready_iter"},     64'(bus.in_ready), 64'd0);
  endtask

  // Count edges from accept until out_valid, bounded by a cycle budget.
  task automatic expect_result(input string tag, input int lat_exp, input logic [ITER_W-1:0] iter_exp,
                               input logic esc_exp, input logic [23:0] rgb_exp);
    int cycles;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!bus.out_valid && cycles < lat_exp + 20);
    check({tag, "_latency"},  64'(cycles),          64'(lat_exp));
    check({tag, "_out_iter"}, 64'(bus.out_iter),    64'(iter_exp));
    check({tag, "_escaped"},  64'(bus.out_escaped), 64'(esc_exp));
    check({tag, "_rgb"},      64'(bus.rgb_out),     64'(rgb_exp));
  endtask

  // One-cycle out_ready; the engine must be idle right after that edge.
  task automatic release_out(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_idle_state"},    64'(state_dbg),     64'd0);
    check({tag, "_idle_in_ready"}, 64'(bus.in_ready),  64'd1);
    check({tag, "_idle_valid"},    64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    // Reset and idle defaults.
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.c_re      = '0;
    bus.c_im      = '0;
    bus.max_iter  = '0;
    bus.mode      = 1'b0;
    bus.jc_re     = '0;
    bus.jc_im     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    // c=0 never escapes: count reaches the limit, valid 101 edges after accept.
    start_job("c0", F_ZERO, F_ZERO, 16'd100, 1'b0, F_ZERO, F_ZERO, 1'b0);
    expect_result("c0", 101, 16'd100, 1'b0, 24'h000000);
    release_out("c0");

    // c=2.5: z1=2.5, |z1|^2=6.25 escapes at n=1.
    start_job("c2p5", F_2P5, F_ZERO, 16'd50, 1'b0, F_ZERO, F_ZERO, 1'b0);
    expect_result("c2p5", 2, 16'd1, 1'b1, 24'h000100);
    release_out("c2p5");

    // c=-2: z settles at 2, |z|^2 == 4 exactly, never escapes.
    start_job("cm2", F_M2P0, F_ZERO, 16'd20, 1'b0, F_ZERO, F_ZERO, 1'b0);
    expect_result("cm2", 21, 16'd20, 1'b0, 24'h000000);
    release_out("cm2");

    // c=1: z = 0,1,2,5; |2|^2=4 stays, |5|^2 escapes at n=3.
    start_job("c1", F_ONE, F_ZERO, 16'd40, 1'b0, F_ZERO, F_ZERO, 1'b0);
    expect_result("c1", 4, 16'd3, 1'b1, 24'h000300);
    release_out("c1");

    // c=i: z cycles 0, i, -1+i, -i, -1+i ... bounded, exercises the imaginary path.
    start_job("ci", F_ZERO, F_ONE, 16'd30, 1'b0, F_ZERO, F_ZERO, 1'b0);
    expect_result("ci", 31, 16'd30, 1'b0, 24'h000000);
    release_out("ci");

    // max_iter=0 with z0=0: one check, no update.
    start_job("mi0", F_ZERO, F_ZERO, 16'd0, 1'b0, F_ZERO, F_ZERO, 1'b0);
    expect_result("mi0", 1, 16'd0, 1'b0, 24'h000000);
    release_out("mi0");

    // Julia z0=3.0, jc=0 escapes immediately; without the feature it is Mandelbrot c=3.
    start_job("julia", F_3P0, F_ZERO, 16'd10, 1'b1, F_ZERO, F_ZERO, 1'b0);
`ifdef FRACTAL_JULIA_EN
    expect_result("julia", 1, 16'd0, 1'b1, 24'h000000);
`else
    expect_result("julia", 2, 16'd1, 1'b1, 24'h000100);
`endif
    release_out("julia");

    // Back-pressure: out_ready low for 10 cycles with a competing request presented.
    start_job("stall", F_2P5, F_ZERO, 16'd50, 1'b0, F_ZERO, F_ZERO, 1'b0);
    expect_result("stall", 2, 16'd1, 1'b1, 24'h000100);
    @(negedge clk);
    bus.c_re     = F_ZERO;
    bus.max_iter = 16'd5;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid",    64'(bus.out_valid),   64'd1);
      check("stall_in_ready", 64'(bus.in_ready),    64'd0);
      check("stall_iter",     64'(bus.out_iter),    64'd1);
      check("stall_escaped",  64'(bus.out_escaped), 64'd1);
      check("stall_rgb",      64'(bus.rgb_out),     64'h000100);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    release_out("stall");

    // Reset in the middle of a long job, then a job on the first edge after release.
    start_job("rst", F_ZERO, F_ZERO, 16'd1000, 1'b0, F_ZERO, F_ZERO, 1'b0);
    repeat (20) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #1;
    check_reset_values("midreset_held");
    start_job("after_rst", F_2P5, F_ZERO, 16'd50, 1'b0, F_ZERO, F_ZERO, 1'b1);
    expect_result("after_rst", 2, 16'd1, 1'b1, 24'h000100);
    release_out("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
